// File: rtl/tl_manager_port_arbiter_pkg.sv
// Shared types, TileLink type constants and beat-count helpers for the
// manager-port arbiter and its outstanding-transaction counters.
package tl_manager_port_arbiter_pkg;

  localparam logic [2:0] PUT_BLOCK          = 3'd3;
  localparam logic [3:0] GNT_GET_DATA_BLOCK = 4'd5;
  localparam logic [3:0] GNT_EXCL_ACK       = 4'd2;
  localparam int         BEATS              = 8;
  localparam logic [2:0] LAST_BEAT          = 3'(BEATS - 1);
  localparam int         CNT_W              = 3;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_e;

  typedef struct packed {
    logic [25:0] addr_block;
    logic        client_xact_id;
    logic [2:0]  addr_beat;
    logic        is_builtin_type;
    logic [2:0]  a_type;
    logic [11:0] union_bits;
    logic [63:0] data;
  } acquire_bits_t;

  function automatic logic is_multibeat_acq(input logic is_builtin_type,
                                            input logic [2:0] a_type);
    return is_builtin_type && (a_type == PUT_BLOCK);
  endfunction

  // Custom (non-builtin) grants carry data except for the exclusive ack.
  function automatic logic is_multibeat_gnt(input logic is_builtin_type,
                                            input logic [3:0] g_type);
    return is_builtin_type ? (g_type == GNT_GET_DATA_BLOCK)
                           : (g_type != GNT_EXCL_ACK);
  endfunction

endpackage

// File: rtl/tl_manager_port_arbiter_ctr.sv
// Saturating up/down counter of outstanding acquires for one client;
// full flags that the client has reached its MAX_OUT limit.
module tl_outstanding_ctr
  import tl_manager_port_arbiter_pkg::*;
#(
  parameter int MAX_OUT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_OUT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && !dec) begin
      if (count != '1) count <= count + CNT_W'(1);
    end else if (dec && !inc) begin
      if (count != '0) count <= count - CNT_W'(1);
    end
  end

  assign full = (count >= LIMIT);

endmodule

// File: rtl/tl_manager_port_arbiter.sv
// Two-client arbiter for the shared TileLink manager port with PutBlock locking,
// grant routing and per-client outstanding limits. CORERISCV_AXI4_ARB_FIXED_PRIO_EN selects fixed priority.
module tl_manager_port_arbiter
  import tl_manager_port_arbiter_pkg::*;
#(
  parameter int MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c0_acquire_valid,
  output logic        c0_acquire_ready,
  input  logic [25:0] c0_acquire_bits_addr_block,
  input  logic        c0_acquire_bits_client_xact_id,
  input  logic [2:0]  c0_acquire_bits_addr_beat,
  input  logic        c0_acquire_bits_is_builtin_type,
  input  logic [2:0]  c0_acquire_bits_a_type,
  input  logic [11:0] c0_acquire_bits_union,
  input  logic [63:0] c0_acquire_bits_data,
  input  logic        c1_acquire_valid,
  output logic        c1_acquire_ready,
  input  logic [25:0] c1_acquire_bits_addr_block,
  input  logic        c1_acquire_bits_client_xact_id,
  input  logic [2:0]  c1_acquire_bits_addr_beat,
  input  logic        c1_acquire_bits_is_builtin_type,
  input  logic [2:0]  c1_acquire_bits_a_type,
  input  logic [11:0] c1_acquire_bits_union,
  input  logic [63:0] c1_acquire_bits_data,
  output logic        mgr_acquire_valid,
  input  logic        mgr_acquire_ready,
  output logic [25:0] mgr_acquire_bits_addr_block,
  output logic        mgr_acquire_bits_client_xact_id,
  output logic [2:0]  mgr_acquire_bits_addr_beat,
  output logic        mgr_acquire_bits_is_builtin_type,
  output logic [2:0]  mgr_acquire_bits_a_type,
  output logic [11:0] mgr_acquire_bits_union,
  output logic [63:0] mgr_acquire_bits_data,
  output logic        mgr_acquire_bits_client_id,
  input  logic        mgr_grant_valid,
  output logic        mgr_grant_ready,
  input  logic [2:0]  mgr_grant_bits_addr_beat,
  input  logic        mgr_grant_bits_client_xact_id,
  input  logic [1:0]  mgr_grant_bits_manager_xact_id,
  input  logic        mgr_grant_bits_is_builtin_type,
  input  logic [3:0]  mgr_grant_bits_g_type,
  input  logic [63:0] mgr_grant_bits_data,
  input  logic        mgr_grant_bits_client_id,
  output logic        c0_grant_valid,
  output logic        c1_grant_valid,
  input  logic        c0_grant_ready,
  input  logic        c1_grant_ready,
  output logic [2:0]  c0_outstanding,
  output logic [2:0]  c1_outstanding
);

  arb_state_e    state_q, state_d;
  logic          lock_id_q, lock_id_d;
  logic [2:0]    beat_cnt_q, beat_cnt_d;
  logic [1:0]    req_valid, full, eligible, inc, dec;
  logic          sel, acq_fire, sel_multibeat, acq_last, gnt_fire, gnt_last;
  acquire_bits_t acq_bits [2];
  acquire_bits_t sel_bits;

  assign req_valid   = {c1_acquire_valid, c0_acquire_valid};
  assign acq_bits[0] = {c0_acquire_bits_addr_block, c0_acquire_bits_client_xact_id,
                        c0_acquire_bits_addr_beat, c0_acquire_bits_is_builtin_type,
                        c0_acquire_bits_a_type, c0_acquire_bits_union, c0_acquire_bits_data};
  assign acq_bits[1] = {c1_acquire_bits_addr_block, c1_acquire_bits_client_xact_id,
                        c1_acquire_bits_addr_beat, c1_acquire_bits_is_builtin_type,
                        c1_acquire_bits_a_type, c1_acquire_bits_union, c1_acquire_bits_data};

`ifdef CORERISCV_AXI4_ARB_FIXED_PRIO_EN
  logic tie_winner;
  assign tie_winner = 1'b0;
`else
  logic rr_q, rr_d, tie_winner;
  assign tie_winner = rr_q;

  // The other client gets the next tie once a transaction's last beat is accepted.
  always_comb begin
    rr_d = rr_q;
    if (acq_fire && acq_last) rr_d = ~sel;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_q <= 1'b0;
    else        rr_q <= rr_d;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      lock_id_q  <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_id_q  <= lock_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_id_d  = lock_id_q;
    beat_cnt_d = beat_cnt_q;
    if (acq_fire) begin
      case (state_q)
        IDLE: begin
          if (sel_multibeat) begin
            state_d    = LOCKED;
            lock_id_d  = sel;
            beat_cnt_d = 3'd1;
          end
        end
        LOCKED: begin
          if (beat_cnt_q == LAST_BEAT) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A locked client is forwarded even when its outstanding count is at the limit.
  always_comb begin
    eligible          = req_valid & ~full;
    sel               = 1'b0;
    mgr_acquire_valid = 1'b0;
    if (state_q == LOCKED) begin
      sel               = lock_id_q;
      mgr_acquire_valid = req_valid[lock_id_q];
    end else begin
      sel               = (&eligible) ? tie_winner : eligible[1];
      mgr_acquire_valid = |eligible;
    end
    c0_acquire_ready = mgr_acquire_valid && !sel && mgr_acquire_ready;
    c1_acquire_ready = mgr_acquire_valid &&  sel && mgr_acquire_ready;
  end

  assign sel_bits                         = acq_bits[sel];
  assign mgr_acquire_bits_addr_block      = sel_bits.addr_block;
  assign mgr_acquire_bits_client_xact_id  = sel_bits.client_xact_id;
  assign mgr_acquire_bits_addr_beat       = sel_bits.addr_beat;
  assign mgr_acquire_bits_is_builtin_type = sel_bits.is_builtin_type;
  assign mgr_acquire_bits_a_type          = sel_bits.a_type;
  assign mgr_acquire_bits_union           = sel_bits.union_bits;
  assign mgr_acquire_bits_data            = sel_bits.data;
  assign mgr_acquire_bits_client_id       = sel;

  assign acq_fire      = mgr_acquire_valid && mgr_acquire_ready;
  assign sel_multibeat = is_multibeat_acq(sel_bits.is_builtin_type, sel_bits.a_type);
  assign acq_last      = (state_q == LOCKED) ? (beat_cnt_q == LAST_BEAT) : !sel_multibeat;
  assign inc[0]        = acq_fire && acq_last && !sel;
  assign inc[1]        = acq_fire && acq_last &&  sel;

  assign c0_grant_valid  = mgr_grant_valid && !mgr_grant_bits_client_id;
  assign c1_grant_valid  = mgr_grant_valid &&  mgr_grant_bits_client_id;
  assign mgr_grant_ready = mgr_grant_bits_client_id ? c1_grant_ready : c0_grant_ready;
  assign gnt_fire        = mgr_grant_valid && mgr_grant_ready;
  assign gnt_last        = !is_multibeat_gnt(mgr_grant_bits_is_builtin_type, mgr_grant_bits_g_type)
                           || (mgr_grant_bits_addr_beat == LAST_BEAT);
  assign dec[0]          = gnt_fire && gnt_last && !mgr_grant_bits_client_id;
  assign dec[1]          = gnt_fire && gnt_last &&  mgr_grant_bits_client_id;

  // Grant payload reaches the clients by broadcast outside this block.
  logic unused_gnt_bits;
  assign unused_gnt_bits = ^{mgr_grant_bits_client_xact_id, mgr_grant_bits_manager_xact_id,
                             mgr_grant_bits_data};

  tl_outstanding_ctr #(.MAX_OUT(MAX_OUT)) u_ctr0 (
    .clk  (clk),
    .reset(reset),
    .inc  (inc[0]),
    .dec  (dec[0]),
    .count(c0_outstanding),
    .full (full[0])
  );

  tl_outstanding_ctr #(.MAX_OUT(MAX_OUT)) u_ctr1 (
    .clk  (clk),
    .reset(reset),
    .inc  (inc[1]),
    .dec  (dec[1]),
    .count(c1_outstanding),
    .full (full[1])
  );

endmodule

// File: tb/tb_tl_manager_port_arbiter.sv
// Self-checking bench for tl_manager_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared each cycle against a transaction-level model.
module tb_tl_manager_port_arbiter;

  localparam int MAX_OUT = 2;
`ifdef CORERISCV_AXI4_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct packed {
    logic [25:0] addr_block;
    logic        xact;
    logic [2:0]  beat;
    logic        builtin;
    logic [2:0]  a_type;
    logic [11:0] un;
    logic [63:0] data;
  } acq_t;

  typedef struct packed {
    logic [2:0]  beat;
    logic        xact;
    logic [1:0]  mxact;
    logic        builtin;
    logic [3:0]  g_type;
    logic [63:0] data;
    logic        cid;
  } gnt_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  acq_t acq [2];
  logic av [2];
  logic gr [2];
  logic mgr_aready;
  gnt_t g;
  logic gv;

  logic        c0_acquire_ready, c1_acquire_ready, mgr_acquire_valid;
  logic [25:0] mgr_acquire_bits_addr_block;
  logic        mgr_acquire_bits_client_xact_id;
  logic [2:0]  mgr_acquire_bits_addr_beat;
  logic        mgr_acquire_bits_is_builtin_type;
  logic [2:0]  mgr_acquire_bits_a_type;
  logic [11:0] mgr_acquire_bits_union;
  logic [63:0] mgr_acquire_bits_data;
  logic        mgr_acquire_bits_client_id;
  logic        mgr_grant_ready, c0_grant_valid, c1_grant_valid;
  logic [2:0]  c0_outstanding, c1_outstanding;

  tl_manager_port_arbiter #(.MAX_OUT(MAX_OUT)) dut (
    .clk                              (clk),
    .reset                            (reset),
    .c0_acquire_valid                 (av[0]),
    .c0_acquire_ready                 (c0_acquire_ready),
    .c0_acquire_bits_addr_block       (acq[0].addr_block),
    .c0_acquire_bits_client_xact_id   (acq[0].xact),
    .c0_acquire_bits_addr_beat        (acq[0].beat),
    .c0_acquire_bits_is_builtin_type  (acq[0].builtin),
    .c0_acquire_bits_a_type           (acq[0].a_type),
    .c0_acquire_bits_union            (acq[0].un),
    .c0_acquire_bits_data             (acq[0].data),
    .c1_acquire_valid                 (av[1]),
    .c1_acquire_ready                 (c1_acquire_ready),
    .c1_acquire_bits_addr_block       (acq[1].addr_block),
    .c1_acquire_bits_client_xact_id   (acq[1].xact),
    .c1_acquire_bits_addr_beat        (acq[1].beat),
    .c1_acquire_bits_is_builtin_type  (acq[1].builtin),
    .c1_acquire_bits_a_type           (acq[1].a_type),
    .c1_acquire_bits_union            (acq[1].un),
    .c1_acquire_bits_data             (acq[1].data),
    .mgr_acquire_valid                (mgr_acquire_valid),
    .mgr_acquire_ready                (mgr_aready),
    .mgr_acquire_bits_addr_block      (mgr_acquire_bits_addr_block),
    .mgr_acquire_bits_client_xact_id  (mgr_acquire_bits_client_xact_id),
    .mgr_acquire_bits_addr_beat       (mgr_acquire_bits_addr_beat),
    .mgr_acquire_bits_is_builtin_type (mgr_acquire_bits_is_builtin_type),
    .mgr_acquire_bits_a_type          (mgr_acquire_bits_a_type),
    .mgr_acquire_bits_union           (mgr_acquire_bits_union),
    .mgr_acquire_bits_data            (mgr_acquire_bits_data),
    .mgr_acquire_bits_client_id       (mgr_acquire_bits_client_id),
    .mgr_grant_valid                  (gv),
    .mgr_grant_ready                  (mgr_grant_ready),
    .mgr_grant_bits_addr_beat         (g.beat),
    .mgr_grant_bits_client_xact_id    (g.xact),
    .mgr_grant_bits_manager_xact_id   (g.mxact),
    .mgr_grant_bits_is_builtin_type   (g.builtin),
    .mgr_grant_bits_g_type            (g.g_type),
    .mgr_grant_bits_data              (g.data),
    .mgr_grant_bits_client_id         (g.cid),
    .c0_grant_valid                   (c0_grant_valid),
    .c1_grant_valid                   (c1_grant_valid),
    .c0_grant_ready                   (gr[0]),
    .c1_grant_ready                   (gr[1]),
    .c0_outstanding                   (c0_outstanding),
    .c1_outstanding                   (c1_outstanding)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: outstanding counts, burst owner (-1 when free), beats taken, next tie winner
  int m_cnt [2];
  int m_owner;
  int m_beats;
  int m_rr;
  int w;
  bit afire, gfire;

  function automatic bit acq_multi(input acq_t a);
    return a.builtin && (a.a_type == 3'd3);
  endfunction

  function automatic bit gnt_multi(input gnt_t x);
    return x.builtin ? (x.g_type == 4'd5) : (x.g_type != 4'd2);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    m_owner  = -1;
    m_beats  = 0;
    m_rr     = 0;
  endtask

  // Work out which client the rules pick this cycle and compare every output.
  task automatic checkOutput();
    bit el0, el1;
    #2;
    if (m_owner >= 0) begin
      w = av[m_owner] ? m_owner : -1;
    end else begin
      el0 = av[0] && (m_cnt[0] < MAX_OUT);
      el1 = av[1] && (m_cnt[1] < MAX_OUT);
      if (el0 && el1) w = FIXED ? 0 : m_rr;
      else if (el0)   w = 0;
      else if (el1)   w = 1;
      else            w = -1;
    end
    afire = (w >= 0) && mgr_aready;
    gfire = gv && gr[g.cid];
    check("mgr_acquire_valid", 64'(mgr_acquire_valid), 64'(w >= 0));
    if (w >= 0) begin
      check("mgr_client_id", 64'(mgr_acquire_bits_client_id), 64'(w));
      check("mgr_acquire_hdr",
            64'({mgr_acquire_bits_addr_block, mgr_acquire_bits_client_xact_id,
                 mgr_acquire_bits_addr_beat, mgr_acquire_bits_is_builtin_type,
                 mgr_acquire_bits_a_type, mgr_acquire_bits_union}),
            64'({acq[w].addr_block, acq[w].xact, acq[w].beat, acq[w].builtin,
                 acq[w].a_type, acq[w].un}));
      check("mgr_acquire_data", mgr_acquire_bits_data, acq[w].data);
    end
    check("c0_acquire_ready", 64'(c0_acquire_ready), 64'((w == 0) && mgr_aready));
    check("c1_acquire_ready", 64'(c1_acquire_ready), 64'((w == 1) && mgr_aready));
    check("c0_grant_valid", 64'(c0_grant_valid), 64'(gv && (g.cid == 1'b0)));
    check("c1_grant_valid", 64'(c1_grant_valid), 64'(gv && (g.cid == 1'b1)));
    check("mgr_grant_ready", 64'(mgr_grant_ready), 64'(gr[g.cid]));
    check("c0_outstanding", 64'(c0_outstanding), 64'(m_cnt[0]));
    check("c1_outstanding", 64'(c1_outstanding), 64'(m_cnt[1]));
  endtask

  task automatic advance();
    int i_inc [2];
    int i_dec [2];
    i_inc[0] = 0; i_inc[1] = 0; i_dec[0] = 0; i_dec[1] = 0;
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else begin
      if (afire) begin
        if (m_owner < 0) begin
          if (acq_multi(acq[w])) begin
            m_owner = w;
            m_beats = 1;
          end else begin
            i_inc[w] = 1;
            m_rr     = 1 - w;
          end
        end else begin
          m_beats++;
          if (m_beats == 8) begin
            i_inc[w] = 1;
            m_owner  = -1;
            m_beats  = 0;
            m_rr     = 1 - w;
          end
        end
      end
      if (gfire && (!gnt_multi(g) || g.beat == 3'd7)) i_dec[g.cid] = 1;
      for (int c = 0; c < 2; c++) begin
        m_cnt[c] += i_inc[c];
        if (i_dec[c] == 1 && m_cnt[c] > 0) m_cnt[c]--;
      end
    end
    #1;
  endtask

  task automatic applyStimulus();
    checkOutput();
    advance();
  endtask

  task automatic set_get(input int c);
    acq[c].addr_block = 26'($urandom);
    acq[c].xact       = 1'($urandom);
    acq[c].beat       = 3'($urandom);
    acq[c].builtin    = 1'b1;
    acq[c].a_type     = 3'd0;
    acq[c].un         = 12'($urandom);
    acq[c].data       = {$urandom, $urandom};
    av[c]             = 1'b1;
  endtask

  task automatic set_put(input int c, input int beat);
    acq[c].addr_block = 26'(c + 100);
    acq[c].xact       = 1'b0;
    acq[c].beat       = 3'(beat);
    acq[c].builtin    = 1'b1;
    acq[c].a_type     = 3'd3;
    acq[c].un         = 12'($urandom);
    acq[c].data       = {$urandom, $urandom};
    av[c]             = 1'b1;
  endtask

  task automatic set_grant(input bit cid, input bit builtin, input int gt, input int beat);
    g.cid     = cid;
    g.builtin = builtin;
    g.g_type  = 4'(gt);
    g.beat    = 3'(beat);
    g.xact    = 1'($urandom);
    g.mxact   = 2'($urandom);
    g.data    = {$urandom, $urandom};
    gv        = 1'b1;
  endtask

  task automatic new_request(input int c);
    if ($urandom_range(0, 3) == 0) begin
      set_put(c, 0);
    end else begin
      set_get(c);
      acq[c].builtin = 1'($urandom);
      acq[c].a_type  = 3'($urandom_range(0, 7));
      if (acq[c].builtin && acq[c].a_type == 3'd3) acq[c].a_type = 3'd1;
    end
  endtask

  task automatic new_grant();
    set_grant(1'($urandom), 1'($urandom), $urandom_range(0, 15), $urandom_range(0, 7));
    if (gnt_multi(g)) g.beat = 3'd0;
  endtask

  initial begin
    int exp_ids [4];
    for (int c = 0; c < 2; c++) begin
      acq[c] = '0;
      av[c]  = 1'b0;
      gr[c]  = 1'b0;
    end
    g = '0;
    gv = 1'b0;
    mgr_aready = 1'b0;
    afire = 1'b0;
    gfire = 1'b0;
    w = -1;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    checkOutput();
    check("reset_mgr_valid", 64'(mgr_acquire_valid), 64'd0);
    check("reset_c0_count", 64'(c0_outstanding), 64'd0);
    check("reset_c1_ready", 64'(c1_acquire_ready), 64'd0);
    reset = 1'b1;
    advance();

    // Back-to-back Gets from both clients until both hit the limit
    if (FIXED) exp_ids = '{0, 0, 1, 1};
    else       exp_ids = '{0, 1, 0, 1};
    set_get(0);
    set_get(1);
    mgr_aready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput();
      check($sformatf("alt_id%0d", i), 64'(mgr_acquire_bits_client_id), 64'(exp_ids[i]));
      advance();
      if (afire) set_get(w);
    end
    checkOutput();
    check("limit_mgr_valid", 64'(mgr_acquire_valid), 64'd0);
    check("limit_c0_count", 64'(c0_outstanding), 64'd2);
    advance();

    // putAck to c0 releases its held third Get
    av[1] = 1'b0;
    set_grant(1'b0, 1'b1, 3, 0);
    gr[0] = 1'b1;
    checkOutput();
    check("putack_grant_ready", 64'(mgr_grant_ready), 64'd1);
    check("third_blocked", 64'(mgr_acquire_valid), 64'd0);
    advance();
    gv = 1'b0;
    checkOutput();
    check("third_released", 64'(mgr_acquire_valid), 64'd1);
    check("third_client_id", 64'(mgr_acquire_bits_client_id), 64'd0);
    check("c0_count_after_ack", 64'(c0_outstanding), 64'd1);
    advance();
    av[0] = 1'b0;

    // Same-cycle acquire and final grant for c0
    set_grant(1'b0, 1'b1, 3, 0);
    applyStimulus();
    set_get(0);
    set_grant(1'b0, 1'b0, 2, 5);
    checkOutput();
    check("simul_acq_ready", 64'(c0_acquire_ready), 64'd1);
    check("simul_grant_valid", 64'(c0_grant_valid), 64'd1);
    advance();
    av[0] = 1'b0;
    gv = 1'b0;
    checkOutput();
    check("simul_count", 64'(c0_outstanding), 64'd1);
    advance();

    // GetDataBlock to c1 held off by c1_grant_ready
    set_grant(1'b1, 1'b1, 5, 0);
    gr[0] = 1'b1;
    gr[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checkOutput();
      check("hold_grant_ready", 64'(mgr_grant_ready), 64'd0);
      check("hold_c1_grant_valid", 64'(c1_grant_valid), 64'd1);
      advance();
    end
    gr[1] = 1'b1;
    for (int b = 0; b < 8; b++) begin
      g.beat = 3'(b);
      g.data = {$urandom, $urandom};
      checkOutput();
      check($sformatf("gdb_count_beat%0d", b), 64'(c1_outstanding), 64'd2);
      advance();
    end
    gv = 1'b0;
    checkOutput();
    check("gdb_count_done", 64'(c1_outstanding), 64'd1);
    advance();

    // PutBlock from c1 locks out c0
    set_put(1, 0);
    checkOutput();
    check("put_beat0_ready", 64'(c1_acquire_ready), 64'd1);
    advance();
    set_get(0);
    for (int b = 1; b < 8; b++) begin
      set_put(1, b);
      checkOutput();
      check($sformatf("lock_c0_ready_b%0d", b), 64'(c0_acquire_ready), 64'd0);
      check($sformatf("lock_id_b%0d", b), 64'(mgr_acquire_bits_client_id), 64'd1);
      advance();
    end
    av[1] = 1'b0;
    checkOutput();
    check("after_lock_valid", 64'(mgr_acquire_valid), 64'd1);
    check("after_lock_id", 64'(mgr_acquire_bits_client_id), 64'd0);
    check("c1_count_after_put", 64'(c1_outstanding), 64'd2);
    advance();
    av[0] = 1'b0;

    // Reset in the middle of a c0 PutBlock
    set_grant(1'b0, 1'b1, 3, 0);
    applyStimulus();
    applyStimulus();
    gv = 1'b0;
    for (int b = 0; b < 4; b++) begin
      set_put(0, b);
      applyStimulus();
    end
    set_put(0, 4);
    checkOutput();
    #1;
    reset = 1'b0;
    av[0] = 1'b0;
    av[1] = 1'b0;
    gv = 1'b0;
    gr[0] = 1'b0;
    gr[1] = 1'b0;
    mgr_aready = 1'b0;
    model_reset();
    #1;
    check("rst_mid_mgr_valid", 64'(mgr_acquire_valid), 64'd0);
    check("rst_mid_c0_count", 64'(c0_outstanding), 64'd0);
    check("rst_mid_c1_count", 64'(c1_outstanding), 64'd0);
    check("rst_mid_c0_ready", 64'(c0_acquire_ready), 64'd0);
    check("rst_mid_grant_ready", 64'(mgr_grant_ready), 64'd0);
    applyStimulus();
    reset = 1'b1;
    set_get(1);
    mgr_aready = 1'b1;
    checkOutput();
    check("post_reset_valid", 64'(mgr_acquire_valid), 64'd1);
    check("post_reset_id", 64'(mgr_acquire_bits_client_id), 64'd1);
    advance();
    av[1] = 1'b0;

    // Randomized traffic against the model
    afire = 1'b0;
    gfire = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      mgr_aready = ($urandom_range(0, 9) < 7);
      gr[0] = ($urandom_range(0, 3) != 0);
      gr[1] = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < 2; c++)
        if (!av[c] && $urandom_range(0, 2) == 0) new_request(c);
      if (!gv && $urandom_range(0, 2) == 0) new_grant();
      applyStimulus();
      if (afire) begin
        if (acq_multi(acq[w]) && acq[w].beat != 3'd7) begin
          acq[w].beat = acq[w].beat + 3'd1;
          acq[w].data = {$urandom, $urandom};
        end else begin
          av[w] = 1'b0;
        end
      end
      if (gfire) begin
        if (gnt_multi(g) && g.beat != 3'd7) begin
          g.beat = g.beat + 3'd1;
          g.data = {$urandom, $urandom};
        end else begin
          gv = 1'b0;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tl_manager_port_arbiter.md
# tl_manager_port_arbiter

Shares the single manager-side TileLink port of the AXI4 manager network between two client requesters (client_id 0 and 1). Arbitrates the acquire channel, holds the grant through 8-beat PutBlock bursts, and routes grants back by client_id. It also caps the outstanding transactions per client. It sits between the client network ports and the manager port adapter, inside the CoreRISCV_AXI4 uncached memory path.

## Interface
- MAX_OUT, default 2: maximum outstanding acquires per client, range 1..7.
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-low.
- c0_acquire_valid / c1_acquire_valid  in  1  client acquire request.
- c0_acquire_ready / c1_acquire_ready  out  1  client acquire accepted.
- cN_acquire_bits_{addr_block[25:0], client_xact_id[0], addr_beat[2:0], is_builtin_type, a_type[2:0], union[11:0], data[63:0]}  in  per-client acquire payload.
- mgr_acquire_valid / mgr_acquire_ready  out/in  1  manager acquire handshake.
- mgr_acquire_bits_* (same fields as the client payload)  out  payload of the selected client.
- mgr_acquire_bits_client_id  out  1  index of the selected client.
- mgr_grant_valid / mgr_grant_ready  in/out  1  manager grant handshake.
- mgr_grant_bits_{addr_beat[2:0], client_xact_id, manager_xact_id[1:0], is_builtin_type, g_type[3:0], data[63:0], client_id}  in  grant payload.
- c0_grant_valid / c1_grant_valid  out  1  routed grant valid. Grant payload is broadcast to both clients.
- c0_grant_ready / c1_grant_ready  in  1  client grant ready.
- c0_outstanding / c1_outstanding  out  3  current outstanding count per client.

## Operation
- **Multi-beat acquire:** is_builtin_type=1 and a_type=3 (PutBlock), 8 beats.
- **Multi-beat grant:** either of the following, 8 beats. All other grants are single-beat.
  - is_builtin_type=1 and g_type=5 (GetDataBlock).
  - is_builtin_type=0 and g_type!=2.
- **Eligibility:** client N is eligible when cN_acquire_valid=1 and cN_outstanding < MAX_OUT. A locked client stays eligible regardless of its count.
- **State machine, IDLE:**
  - Select among eligible clients using round-robin pointer rr; the pointed-to client wins ties.
  - On the first beat of a multi-beat acquire firing, go to LOCKED(sel) with beat_cnt=1.
  - On a single-beat fire, rr = ~sel.
- **State machine, LOCKED(k):**
  - Only client k is forwarded; the other client's ready is 0.
  - Each fire increments beat_cnt.
  - The fire at beat_cnt=7 returns to IDLE, wraps beat_cnt to 0, and sets rr = ~k.
- **Forwarding:**
  - mgr_acquire_valid = valid of the selected eligible client.
  - Selected cN_acquire_ready = mgr_acquire_ready; the non-selected client's ready is 0.
- **Outstanding counters:**
  - Increment on the final acquire beat firing: a single-beat fire, or beat 7 of a PutBlock.
  - Decrement on the final grant beat firing to that client: a single-beat grant, or addr_beat=7 of a multi-beat grant.
  - Same-cycle increment and decrement for one client leaves the count unchanged.
  - A decrement at 0 saturates at 0.
- **Grant routing:**
  - cN_grant_valid = mgr_grant_valid and (client_id==N).
  - mgr_grant_ready = cN_grant_ready of the addressed client.
- **Reset values:** state IDLE, rr=0, beat_cnt=0, both counters 0. This makes all valid/ready outputs 0 unless driven combinationally by inputs.
- **Reset mid-burst:** asserting reset mid-burst abandons the lock immediately. Upstream is reset together with this block.

## Timing
- Zero-latency combinational paths on both channels: acquire fields, valid/ready, and grants.
- No registered stage.
- Selection depends only on registered state (state, rr, counts) and input valids. mgr_acquire_valid never depends on mgr_acquire_ready.
- State, rr, beat_cnt and counters update on the rising clk edge after a fire.
- Once a client asserts valid, it holds valid and payload until it fires; the selection does not change while mgr_acquire_valid=1 and mgr_acquire_ready=0.
- Back-to-back single-beat acquires from both clients alternate every cycle.

## Configuration
- **CORERISCV_AXI4_ARB_FIXED_PRIO_EN defined:** client 0 always wins ties in IDLE and the rr register is removed. Locking and the outstanding limit are unchanged.
- **Undefined (default):** round-robin as described above.

## Structure
- **Shared package:**
  - Acquire type constants: PUT_BLOCK=3'd3.
  - Grant type constants: GNT_GET_DATA_BLOCK=4'd5, GNT_EXCL_ACK=4'd2.
  - BEATS=8.
  - State enum: IDLE, LOCKED.
  - Function is_multibeat_acq().
  - Function is_multibeat_gnt().
- **Sub-module:** tl_outstanding_ctr, instantiated twice. It is a saturating up/down counter with inc, dec and MAX_OUT parameter inputs, and outputs count and full.

## Test plan
- **Single-beat alternation:** c0 and c1 both issue single-beat Get (a_type=0) continuously with mgr_acquire_ready=1. Required: mgr_acquire_bits_client_id sequence 0,1,0,1. The macro-defined build gives all 0 until c0's count reaches MAX_OUT.
- **PutBlock lock:** c1 issues a PutBlock with addr_beat 0..7 while c0 is valid. Required: c0_acquire_ready=0 for all 8 beats, and c0 is selected on the cycle after beat 7.
- **Outstanding limit:** MAX_OUT=2, c0 issues 3 Gets with no grants. Required: the third is not forwarded and c0_outstanding=2. A putAck grant (builtin, g_type=3, client_id=0) with c0_grant_ready=1 releases the third the next cycle.
- **Grant routing:** a GetDataBlock grant (8 beats, client_id=1) is held with c1_grant_ready=0 for 2 cycles. Required: mgr_grant_ready=0 during the hold, and c1_outstanding decrements only after addr_beat=7 fires.
- **Simultaneous events:** a c0 acquire fire and a c0 final grant fire in the same cycle. Required: the count is unchanged.
- **Reset mid-burst:** reset asserted at beat 4 of a PutBlock. Required: state IDLE, counts 0 and rr=0 immediately; all outputs are inactive while the inputs are idle.
